cache_subsystem_param: RTL and testbench

- Parametrised successor to the fixed cache + RAM subsystem: a direct-mapped, write-through, no-write-allocate L1D cache and a behavioural main memory with configurable latency in one top.
- Cache refills whole lines word-serially over an internal memory bus.
- Sits between the core load/store port and the memory model; the core sees one ready/valid/storeDone handshake.

---
 rtl/cache_subsystem_param.sv | 214 +++++++++++++++++++++
 tb/tb_cache_subsystem_param.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/cache_subsystem_param.sv
// cache_subsystem_param: direct-mapped, write-through, no-write-allocate L1D
// cache in front of a behavioural main memory with per-word access latency.
// Lines are refilled word-serially. The core sees a single ready/valid/storeDone
// handshake.
// Optional feature macro: CACHE_STATS_EN. When it is defined, hitCount and
// missCount are live saturating counters. When it is not defined, both ports
// are tied to zero.
module cache_subsystem_param #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int NUM_LINES      = 16,
  parameter int WORDS_PER_LINE = 4,
  parameter int MEM_DEPTH      = 1024,
  parameter int MEM_LATENCY    = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] inputAddress,
  input  logic [DATA_WIDTH-1:0] inputData,
  input  logic                  loadEnable,
  input  logic                  storeEnable,
  output logic                  ready,
  output logic                  valid,
  output logic [DATA_WIDTH-1:0] dataOut,
  output logic                  storeDone,
  output logic                  hit,
  output logic [15:0]           hitCount,
  output logic [15:0]           missCount
);

  localparam int OFF_BITS = $clog2(WORDS_PER_LINE);
  localparam int OFF_W    = (OFF_BITS == 0) ? 1 : OFF_BITS;
  localparam int IDX_BITS = $clog2(NUM_LINES);
  localparam int TAG_BITS = ADDR_WIDTH - OFF_BITS - IDX_BITS;
  localparam int MEM_BITS = $clog2(MEM_DEPTH);
  localparam int LAT_W    = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

  typedef enum logic [2:0] {IDLE, LOOKUP, REFILL, WRITE, RESPOND} state_t;
  typedef logic [DATA_WIDTH-1:0] memArray_t [MEM_DEPTH];

  // Main memory starts with every word holding its own index.
  function automatic memArray_t memInit();
    memArray_t m;
    for (int i = 0; i < MEM_DEPTH; i++) m[i] = DATA_WIDTH'(i);
    return m;
  endfunction

  memArray_t mem = memInit();

  logic [DATA_WIDTH-1:0] lineData [NUM_LINES][WORDS_PER_LINE];
  logic [TAG_BITS-1:0]   lineTag  [NUM_LINES];
  logic [NUM_LINES-1:0]  lineValid;

  state_t                state;
  logic [ADDR_WIDTH-1:0] reqAddr;
  logic [DATA_WIDTH-1:0] reqData;
  logic                  reqIsLoad;
  logic [OFF_W-1:0]      wordCnt;
  logic [LAT_W-1:0]      latCnt;
  logic [DATA_WIDTH-1:0] fillWord;

  logic [OFF_W-1:0]      reqOffset;
  logic [IDX_BITS-1:0]   reqIndex;
  logic [TAG_BITS-1:0]   reqTag;
  logic [ADDR_WIDTH-1:0] refillAddr;
  logic [MEM_BITS-1:0]   memWordAddr;
  logic [DATA_WIDTH-1:0] memRdata;
  logic                  lookupHit;
  logic                  lastBeat;
  logic                  lastWord;
  logic                  lineWe;
  logic [OFF_W-1:0]      lineWOff;
  logic [DATA_WIDTH-1:0] lineWData;
  logic                  tagWe;
  logic                  memWe;

  assign reqOffset  = (OFF_BITS == 0) ? '0 : OFF_W'(reqAddr);
  assign reqIndex   = IDX_BITS'(reqAddr >> OFF_BITS);
  assign reqTag     = TAG_BITS'(reqAddr >> (OFF_BITS + IDX_BITS));
  assign refillAddr = (reqAddr & ~ADDR_WIDTH'(WORDS_PER_LINE - 1)) | ADDR_WIDTH'(wordCnt);
  assign lookupHit  = lineValid[reqIndex] && (lineTag[reqIndex] == reqTag);
  assign lastBeat   = (latCnt == LAT_W'(MEM_LATENCY - 1));
  assign lastWord   = (wordCnt == OFF_W'(WORDS_PER_LINE - 1));
  assign memRdata   = mem[memWordAddr];

  // Memory address and write enables for the line store, the tag store and memory.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can leave one unassigned and infer a latch.
    memWordAddr = MEM_BITS'(reqAddr);
    lineWe      = 1'b0;
    lineWOff    = reqOffset;
    lineWData   = reqData;
    tagWe       = 1'b0;
    memWe       = 1'b0;
    if (!reset) begin
      unique case (state)
        LOOKUP:  lineWe = !reqIsLoad && lookupHit;
        REFILL: begin
          memWordAddr = MEM_BITS'(refillAddr);
          lineWe      = lastBeat;
          lineWOff    = wordCnt;
          lineWData   = memRdata;
          tagWe       = lastBeat && lastWord;
        end
        WRITE:   memWe = lastBeat;
        default: ;
      endcase
    end
  end

  // Line data, tags and memory contents. These arrays are written only; reset does not clear them.
  // NOTE: large arrays are deliberately left out of reset. The valid bits alone mark whether a line holds usable data.
  always_ff @(posedge clk) begin
    if (lineWe) lineData[reqIndex][lineWOff] <= lineWData;
    if (tagWe)  lineTag[reqIndex] <= reqTag;
    if (memWe)  mem[memWordAddr] <= reqData;
  end

  // Request FSM: accept, lookup, refill or write-through, then the response pulse.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only, so every register samples the values from before this edge.
    if (reset) begin
      state     <= IDLE;
      lineValid <= '0;
      ready     <= 1'b1;
      valid     <= 1'b0;
      storeDone <= 1'b0;
      hit       <= 1'b0;
      dataOut   <= '0;
      reqAddr   <= '0;
      reqData   <= '0;
      reqIsLoad <= 1'b0;
      wordCnt   <= '0;
      latCnt    <= '0;
      fillWord  <= '0;
    end else begin
      valid     <= 1'b0;
      storeDone <= 1'b0;
      unique case (state)
        IDLE: begin
          if (loadEnable || storeEnable) begin
            reqAddr   <= inputAddress;
            reqData   <= inputData;
            reqIsLoad <= loadEnable;
            ready     <= 1'b0;
            state     <= LOOKUP;
          end
        end
        LOOKUP: begin
          hit     <= lookupHit;
          wordCnt <= '0;
          latCnt  <= '0;
          if (!reqIsLoad) begin
            state <= WRITE;
          end else if (lookupHit) begin
            dataOut <= lineData[reqIndex][reqOffset];
            valid   <= 1'b1;
            state   <= RESPOND;
          end else begin
            state <= REFILL;
          end
        end
        REFILL: begin
          if (!lastBeat) begin
            latCnt <= latCnt + 1'b1;
          end else begin
            latCnt <= '0;
            if (wordCnt == reqOffset) fillWord <= memRdata;
            if (lastWord) begin
              // The requested word may be the one arriving on this beat.
              dataOut             <= (wordCnt == reqOffset) ? memRdata : fillWord;
              lineValid[reqIndex] <= 1'b1;
              valid               <= 1'b1;
              state               <= RESPOND;
            end else begin
              wordCnt <= wordCnt + 1'b1;
            end
          end
        end
        WRITE: begin
          if (!lastBeat) begin
            latCnt <= latCnt + 1'b1;
          end else begin
            storeDone <= 1'b1;
            state     <= RESPOND;
          end
        end
        RESPOND: begin
          hit   <= 1'b0;
          ready <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef CACHE_STATS_EN
  // Saturating hit and miss counters. Each completed request bumps exactly one of them.
  always_ff @(posedge clk) begin
    if (reset) begin
      hitCount  <= '0;
      missCount <= '0;
    end else if (state == RESPOND) begin
      if (hit && hitCount != 16'hFFFF)        hitCount  <= hitCount + 16'd1;
      else if (!hit && missCount != 16'hFFFF) missCount <= missCount + 16'd1;
    end
  end
`else
  assign hitCount  = 16'd0;
  assign missCount = 16'd0;
`endif

endmodule

// File: tb/tb_cache_subsystem_param.sv
// Self-checking bench for cache_subsystem_param (default parameters).
// The reference model tracks memory contents plus the tag and valid bit of
// each line. From those it predicts hit/miss, latency and load data.
module tb_cache_subsystem_param;

  localparam int DW  = 32;
  localparam int AW  = 32;
  localparam int NL  = 16;
  localparam int WPL = 4;
  localparam int MD  = 1024;
  localparam int LAT = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [AW-1:0] inputAddress = '0;
  logic [DW-1:0] inputData = '0;
  logic          loadEnable = 1'b0;
  logic          storeEnable = 1'b0;
  logic          ready, valid, storeDone, hit;
  logic [DW-1:0] dataOut;
  logic [15:0]   hitCount, missCount;

  cache_subsystem_param #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_LINES(NL),
    .WORDS_PER_LINE(WPL), .MEM_DEPTH(MD), .MEM_LATENCY(LAT)
  ) dut (
    .clk(clk), .reset(reset), .inputAddress(inputAddress), .inputData(inputData),
    .loadEnable(loadEnable), .storeEnable(storeEnable), .ready(ready), .valid(valid),
    .dataOut(dataOut), .storeDone(storeDone), .hit(hit),
    .hitCount(hitCount), .missCount(missCount)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state.
  logic [DW-1:0] modelMem [MD];
  bit            modelValid [NL];
  int unsigned   modelTag [NL];
  int unsigned   modelHits = 0;
  int unsigned   modelMisses = 0;

  task automatic check(input string tagName, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tagName, actual, expected);
    end
  endtask

  task automatic modelReset();
    for (int i = 0; i < NL; i++) modelValid[i] = 1'b0;
    modelHits = 0;
    modelMisses = 0;
  endtask

  // Issue one request and check latency, hit, data and the ready profile.
  // With holdEn set, the enables stay high until the response pulse.
  task automatic doReq(input bit ld, input bit st, input int unsigned addr,
                       input logic [DW-1:0] data, input bit holdEn, input string name);
    int unsigned idx, tg, expLat, cycle, waitCnt;
    bit expHit, isLoad, readyLow, wrongPulse, pulse;
    logic [DW-1:0] expData;
    isLoad = ld;
    idx    = (addr / WPL) % NL;
    tg     = addr / (WPL * NL);
    expHit = modelValid[idx] && (modelTag[idx] == tg);
    expData = modelMem[addr % MD];
    if (isLoad) begin
      expLat = expHit ? 2 : 2 + WPL * LAT;
      if (!expHit) begin
        modelValid[idx] = 1'b1;
        modelTag[idx]   = tg;
      end
    end else begin
      expLat = 2 + LAT;
      modelMem[addr % MD] = data;
    end
    if (expHit) modelHits++; else modelMisses++;

    @(negedge clk);
    waitCnt = 0;
    while (!ready && waitCnt < 100) begin
      @(negedge clk);
      waitCnt++;
    end
    if (!ready) check({name, "_readyWait"}, 32'(ready), 32'd1);
    inputAddress = AW'(addr);
    inputData    = data;
    loadEnable   = ld;
    storeEnable  = st;
    readyLow = 1'b1;
    wrongPulse = 1'b0;
    pulse = 1'b0;
    for (cycle = 1; cycle <= 60; cycle++) begin
      @(negedge clk);
      if (!holdEn && cycle == 1) begin
        loadEnable  = 1'b0;
        storeEnable = 1'b0;
      end
      if (ready) readyLow = 1'b0;
      if (isLoad ? storeDone : valid) wrongPulse = 1'b1;
      pulse = isLoad ? valid : storeDone;
      if (pulse) break;
    end
    loadEnable  = 1'b0;
    storeEnable = 1'b0;
    check({name, "_latency"}, cycle, expLat);
    check({name, "_hit"}, 32'(hit), 32'(expHit));
    if (isLoad) check({name, "_data"}, dataOut, expData);
    check({name, "_readyLowWhileBusy"}, 32'(readyLow), 32'd1);
    check({name, "_noWrongPulse"}, 32'(wrongPulse), 32'd0);
    @(negedge clk);
    check({name, "_readyAfter"}, 32'(ready), 32'd1);
  endtask

  task automatic checkStats(input string name);
`ifdef CACHE_STATS_EN
    check({name, "_hitCount"}, 32'(hitCount), modelHits);
    check({name, "_missCount"}, 32'(missCount), modelMisses);
`else
    check({name, "_hitCountTied"}, 32'(hitCount), 32'd0);
    check({name, "_missCountTied"}, 32'(missCount), 32'd0);
`endif
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit quiet;
    for (int i = 0; i < MD; i++) modelMem[i] = DW'(i);
    modelReset();

    // Reset state.
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("reset_ready", 32'(ready), 32'd1);
    check("reset_valid", 32'(valid), 32'd0);
    check("reset_storeDone", 32'(storeDone), 32'd0);
    check("reset_hit", 32'(hit), 32'd0);
    check("reset_dataOut", dataOut, 32'd0);
    checkStats("reset");

    // Cold miss, then a hit in the same line.
    doReq(1, 0, 'h25, '0, 0, "coldLoad");
    doReq(1, 0, 'h24, '0, 0, "reloadHit");
    checkStats("afterCold");

    // Store hit updates the line; a store miss does not allocate a line.
    doReq(0, 1, 'h26, 32'hDEAD, 0, "storeHit");
    doReq(1, 0, 'h26, '0, 0, "loadAfterStoreHit");
    doReq(0, 1, 'h100, 32'hBEEF, 0, "storeMiss");
    doReq(1, 0, 'h100, '0, 0, "loadAfterStoreMiss");

    // Conflict eviction within one index.
    doReq(1, 0, 'h04, '0, 0, "conflictA");
    doReq(1, 0, 'h44, '0, 0, "conflictB");
    doReq(1, 0, 'h04, '0, 0, "conflictAagain");

    // Both enables together: the load wins and the store is dropped.
    doReq(1, 1, 'h10, 32'hFFFF_FFFF, 0, "bothEnables");
    doReq(1, 0, 'h10, '0, 0, "memUnchanged");

    // Enables held high while busy must not cause extra accepts.
    doReq(0, 1, 'h50, 32'h1234, 1, "heldStore");
    quiet = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (valid || storeDone || !ready) quiet = 1'b0;
    end
    check("heldStore_noExtraAccept", 32'(quiet), 32'd1);
    doReq(1, 0, 'h50, '0, 1, "heldLoad");
    quiet = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (valid || storeDone || !ready) quiet = 1'b0;
    end
    check("heldLoad_noExtraAccept", 32'(quiet), 32'd1);
    checkStats("afterDirected");

    // Reset in the middle of a refill.
    @(negedge clk);
    inputAddress = 'h30;
    loadEnable   = 1'b1;
    @(negedge clk);
    loadEnable   = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    modelReset();
    check("midReset_ready", 32'(ready), 32'd1);
    check("midReset_valid", 32'(valid), 32'd0);
    doReq(1, 0, 'h30, '0, 0, "afterMidReset");
    checkStats("afterMidReset");

    // Randomised mix of loads, stores and both-enable requests.
    for (int n = 0; n < 80; n++) begin
      int unsigned op, a;
      op = $urandom_range(0, 2);
      a  = $urandom_range(0, 511);
      doReq(op != 1, op != 0, a, DW'($urandom), ($urandom_range(0, 3) == 0), $sformatf("rand%0d", n));
    end
    checkStats("final");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
